// File: rtl/cp0_unit_if.sv
// Controller <-> CP0 bundle: decoded CP0 strobes and operands in, register
// read data, Status and the PC redirect out.
interface cp0_unit_if;
  logic        ena;
  logic        mfc0;
  logic        mtc0;
  logic        eret;
  logic [4:0]  cause;
  logic [31:0] pc;
  logic [4:0]  rd;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] status;
  logic [31:0] exc_addr;
  logic        exc_taken;
  logic        timer_irq;

  modport master (
    output ena, mfc0, mtc0, eret, cause, pc, rd, wdata,
    input  rdata, status, exc_addr, exc_taken, timer_irq
  );

  modport slave (
    input  ena, mfc0, mtc0, eret, cause, pc, rd, wdata,
    output rdata, status, exc_addr, exc_taken, timer_irq
  );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor-0: Status/Cause/EPC, exception entry/return and PC redirect.
// Optional Count/Compare timer enabled by defining CP0_TIMER_EN.
module cp0_unit #(
  parameter logic [31:0] EXC_VECTOR = 32'h0040_0004
) (
  input logic       clk,
  input logic       rst,
  cp0_unit_if.slave bus
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  logic [31:0] status_q, cause_q, epc_q;
  logic [31:0] status_d, cause_d, epc_d;
  logic        code_ok, en_bit, exc_taken, eret_go, wr_en;
  logic [31:0] rdata;

  // mfc0 only qualifies the read in the controller; the read path is free-running.
  logic unused_mfc0;
  assign unused_mfc0 = bus.mfc0;

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, compare_q, count_d, compare_d;
  logic        timer_match;
  assign timer_match = (count_q == compare_q) && (compare_q != 32'd0);
`endif

  // Each exception code is gated by Status[0] and its own enable bit.
  always_comb begin
    code_ok = 1'b0;
    en_bit  = 1'b0;
    case (bus.cause)
      5'd8:    begin code_ok = 1'b1; en_bit = status_q[1]; end
      5'd9:    begin code_ok = 1'b1; en_bit = status_q[2]; end
      5'd13:   begin code_ok = 1'b1; en_bit = status_q[3]; end
      default: ;
    endcase
  end

  assign exc_taken = bus.ena & code_ok & status_q[0] & en_bit;
  assign eret_go   = bus.ena & bus.eret & ~exc_taken;
  assign wr_en     = bus.ena & bus.mtc0 & ~exc_taken & ~bus.eret;

  // NOTE: every next-state value gets a default first so no latch is inferred.
  always_comb begin
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    if (exc_taken) begin
      status_d      = status_q << 5;
      cause_d[6:2]  = bus.cause;
      epc_d         = bus.pc;
    end else if (eret_go) begin
      status_d = status_q >> 5;
    end else if (wr_en) begin
      case (bus.rd)
        REG_STATUS: status_d = bus.wdata;
        REG_CAUSE:  cause_d  = bus.wdata;
        REG_EPC:    epc_d    = bus.wdata;
        default:    ;
      endcase
    end
`ifdef CP0_TIMER_EN
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    if (wr_en && bus.rd == REG_COUNT) count_d = bus.wdata;
    // Writing Compare acknowledges the pending timer interrupt.
    if (wr_en && bus.rd == REG_COMPARE) begin
      compare_d   = bus.wdata;
      cause_d[15] = 1'b0;
    end else if (timer_match) begin
      cause_d[15] = 1'b1;
    end
`else
    cause_d[15] = 1'b0;
`endif
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= '0;
      cause_q  <= '0;
      epc_q    <= '0;
`ifdef CP0_TIMER_EN
      count_q   <= '0;
      compare_q <= '0;
`endif
    end else begin
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
`ifdef CP0_TIMER_EN
      count_q   <= count_d;
      compare_q <= compare_d;
`endif
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.rd)
      REG_STATUS:  rdata = status_q;
      REG_CAUSE:   rdata = cause_q;
      REG_EPC:     rdata = epc_q;
`ifdef CP0_TIMER_EN
      REG_COUNT:   rdata = count_q;
      REG_COMPARE: rdata = compare_q;
`endif
      default:     ;
    endcase
  end

  assign bus.rdata     = rdata;
  assign bus.status    = status_q;
  assign bus.exc_taken = exc_taken;
  // eret redirect has precedence over the vector on the npc mux.
  assign bus.exc_addr  = bus.eret ? epc_q : (exc_taken ? EXC_VECTOR : 32'd0);
`ifdef CP0_TIMER_EN
  assign bus.timer_irq = cause_q[15] & status_q[15] & status_q[0];
`else
  assign bus.timer_irq = 1'b0;
`endif

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed scenarios plus random traffic
// compared against a register-array reference model.
module tb_cp0_unit;
  localparam logic [31:0] VEC = 32'h0040_0004;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cp0_unit_if bus ();
  cp0_unit #(.EXC_VECTOR(VEC)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m [0:31];
  logic        obs_taken, obs_irq;
  logic [31:0] obs_addr, obs_rdata;

`ifdef CP0_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit implemented(input logic [4:0] a);
    return (a == 5'd12) || (a == 5'd13) || (a == 5'd14) ||
           (TIMER && ((a == 5'd9) || (a == 5'd11)));
  endfunction

  function automatic bit m_taken(input logic e, input logic [4:0] c);
    int b;
    b = (c == 5'd8) ? 1 : (c == 5'd9) ? 2 : (c == 5'd13) ? 3 : 0;
    return e && (b != 0) && m[12][0] && m[12][b];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m[i] = 32'd0;
  endtask

  task automatic model_edge(input logic r, input logic e, input logic mt, input logic er,
                            input logic [4:0] c, input logic [31:0] p,
                            input logic [4:0] a, input logic [31:0] wd);
    logic [31:0] old [0:31];
    bit tk, wr;
    if (r) begin
      model_reset();
      return;
    end
    old = m;
    tk  = m_taken(e, c);
    wr  = e && mt && !tk && !er;
    if (tk) begin
      m[12]      = old[12] << 5;
      m[13][6:2] = c;
      m[14]      = p;
    end else if (e && er) begin
      m[12] = old[12] >> 5;
    end else if (wr && implemented(a)) begin
      m[a] = wd;
    end
    if (TIMER) begin
      m[9] = (wr && a == 5'd9) ? wd : old[9] + 32'd1;
      if (wr && a == 5'd11) m[13][15] = 1'b0;
      else if (old[9] == old[11] && old[11] != 32'd0) m[13][15] = 1'b1;
    end else begin
      m[13][15] = 1'b0;
    end
  endtask

  // One instruction cycle: drive at negedge, compare combinational outputs,
  // advance the model on the posedge.
  task automatic do_cycle(input logic r, input logic e, input logic mf, input logic mt,
                          input logic er, input logic [4:0] c, input logic [31:0] p,
                          input logic [4:0] a, input logic [31:0] wd);
    logic [31:0] exp_addr;
    bit tk;
    rst = r; bus.ena = e; bus.mfc0 = mf; bus.mtc0 = mt; bus.eret = er;
    bus.cause = c; bus.pc = p; bus.rd = a; bus.wdata = wd;
    #1;
    tk       = m_taken(e, c);
    exp_addr = er ? m[14] : (tk ? VEC : 32'd0);
    obs_taken = bus.exc_taken;
    obs_addr  = bus.exc_addr;
    obs_rdata = bus.rdata;
    obs_irq   = bus.timer_irq;
    check("exc_taken", {31'd0, bus.exc_taken}, {31'd0, tk});
    check("exc_addr", bus.exc_addr, exp_addr);
    check("rdata", bus.rdata, implemented(a) ? m[a] : 32'd0);
    check("status", bus.status, m[12]);
    check("timer_irq", {31'd0, bus.timer_irq},
          {31'd0, TIMER && m[13][15] && m[12][15] && m[12][0]});
    @(posedge clk);
    model_edge(r, e, mt, er, c, p, a, wd);
    @(negedge clk);
  endtask

  task automatic rd_reg(input logic [4:0] a);
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, a, 32'd0);
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] wd);
    do_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, a, wd);
  endtask

  task automatic exc(input logic [4:0] c, input logic [31:0] p);
    do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, c, p, 5'd13, 32'd0);
  endtask

  logic [4:0]  rc, ra;
  logic [31:0] rw;
  bit          seen;

  initial begin
    rst = 1'b1; bus.ena = 1'b0; bus.mfc0 = 1'b0; bus.mtc0 = 1'b0; bus.eret = 1'b0;
    bus.cause = 5'd0; bus.pc = 32'd0; bus.rd = 5'd0; bus.wdata = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state and masked syscall.
    rd_reg(5'd12); check("reset_status", obs_rdata, 32'd0);
    rd_reg(5'd13); check("reset_cause", obs_rdata, 32'd0);
    rd_reg(5'd14); check("reset_epc", obs_rdata, 32'd0);
    exc(5'd8, 32'h0040_0100);
    check("masked_syscall", {31'd0, obs_taken}, 32'd0);
    rd_reg(5'd13); check("masked_cause", obs_rdata, 32'd0);
    rd_reg(5'd14); check("masked_epc", obs_rdata, 32'd0);

    // Enabled syscall then eret.
    wr_reg(5'd12, 32'h0000_000F);
    exc(5'd8, 32'h0040_0100);
    check("syscall_taken", {31'd0, obs_taken}, 32'd1);
    check("syscall_vec", obs_addr, 32'h0040_0004);
    rd_reg(5'd12); check("syscall_status", obs_rdata, 32'h0000_01E0);
    rd_reg(5'd13); check("syscall_cause", obs_rdata, 32'h0000_0020);
    rd_reg(5'd14); check("syscall_epc", obs_rdata, 32'h0040_0100);
    do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 5'd12, 32'd0);
    check("eret_addr", obs_addr, 32'h0040_0100);
    rd_reg(5'd12); check("eret_status", obs_rdata, 32'h0000_000F);

    // BREAK masked, TEQ taken.
    wr_reg(5'd12, 32'h0000_0009);
    exc(5'd9, 32'h0040_0200);
    check("break_masked", {31'd0, obs_taken}, 32'd0);
    exc(5'd13, 32'h0040_0300);
    check("teq_taken", {31'd0, obs_taken}, 32'd1);
    rd_reg(5'd13); check("teq_cause", obs_rdata, 32'h0000_0034);
    rd_reg(5'd12); check("teq_status", obs_rdata, 32'h0000_0120);

    // Exception and mtc0 Status in the same cycle: exception wins.
    wr_reg(5'd12, 32'h0000_000F);
    do_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd8, 32'h0040_0400, 5'd12, 32'h0000_FFFF);
    rd_reg(5'd12); check("prio_status", obs_rdata, 32'h0000_01E0);
    rd_reg(5'd14); check("prio_epc", obs_rdata, 32'h0040_0400);

    // Reset with an exception in flight drops it.
    wr_reg(5'd12, 32'h0000_000F);
    do_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 32'h0040_0500, 5'd12, 32'd0);
    rd_reg(5'd12); check("rst_status", obs_rdata, 32'd0);
    rd_reg(5'd14); check("rst_epc", obs_rdata, 32'd0);

`ifdef CP0_TIMER_EN
    wr_reg(5'd11, 32'd20);
    wr_reg(5'd12, 32'h0000_8001);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      rd_reg(5'd9);
      if (obs_irq) seen = 1'b1;
    end
    check("timer_irq_rise", {31'd0, seen}, 32'd1);
    wr_reg(5'd11, 32'd50);
    rd_reg(5'd13);
    check("timer_irq_clear", {31'd0, obs_irq}, 32'd0);
    wr_reg(5'd9, 32'hFFFF_FFFF);
    rd_reg(5'd9); check("count_max", obs_rdata, 32'hFFFF_FFFF);
    rd_reg(5'd9); check("count_wrap", obs_rdata, 32'd0);
`else
    wr_reg(5'd9, 32'h1234_5678);
    rd_reg(5'd9); check("no_count", obs_rdata, 32'd0);
    wr_reg(5'd13, 32'hFFFF_FFFF);
    rd_reg(5'd13); check("no_cause15", obs_rdata, 32'hFFFF_7FFF);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0: rc = 5'd8;
        1: rc = 5'd9;
        2: rc = 5'd13;
        3: rc = 5'd0;
        default: rc = 5'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: ra = 5'd9;
        1: ra = 5'd11;
        2: ra = 5'd12;
        3: ra = 5'd13;
        4: ra = 5'd14;
        default: ra = 5'($urandom);
      endcase
      rw = $urandom;
      if (ra == 5'd12 && $urandom_range(0, 1) == 0) rw = rw | 32'h0000_800F;
      do_cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) != 0),
               1'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
               rc, $urandom, ra, rw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
